// File: rtl/renode_axi_pkg.sv
// Shared AXI types for the Renode burst splitter: burst/response encodings, FSM states,
// and a helper that keeps the most severe response seen across a burst.
package renode_axi_pkg;

    typedef enum logic [1:0] {
        BurstFixed    = 2'b00,
        BurstIncr     = 2'b01,
        BurstWrap     = 2'b10,
        BurstReserved = 2'b11
    } burst_type_e;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExOkay = 2'b01,
        RespSlvErr = 2'b10,
        RespDecErr = 2'b11
    } response_e;

    typedef logic [2:0] burst_size_t;
    typedef logic [7:0] burst_length_t;

    typedef enum logic [2:0] {
        WIdle,
        WAddr,
        WData,
        WResp,
        WBresp,
        WDrain
    } w_state_e;

    typedef enum logic [2:0] {
        RIdle,
        RAddr,
        RData,
        ROut,
        RErr
    } r_state_e;

    // Higher encoding is the more severe response (DECERR outranks SLVERR).
    function automatic response_e max_response(response_e a, response_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/renode_axi_burst_splitter_if.sv
// Full AXI4 port bundle used on both sides of the burst splitter.
interface renode_axi_burst_splitter_if #(
    parameter int unsigned AddressWidth       = 32,
    parameter int unsigned DataWidth          = 32,
    parameter int unsigned TransactionIdWidth = 8
);
    localparam int unsigned StrobeWidth = DataWidth / 8;

    logic [TransactionIdWidth-1:0] awid;
    logic [AddressWidth-1:0]       awaddr;
    logic [7:0]                    awlen;
    logic [2:0]                    awsize;
    logic [1:0]                    awburst;
    logic                          awvalid;
    logic                          awready;

    logic [DataWidth-1:0]          wdata;
    logic [StrobeWidth-1:0]        wstrb;
    logic                          wlast;
    logic                          wvalid;
    logic                          wready;

    logic [TransactionIdWidth-1:0] bid;
    logic [1:0]                    bresp;
    logic                          bvalid;
    logic                          bready;

    logic [TransactionIdWidth-1:0] arid;
    logic [AddressWidth-1:0]       araddr;
    logic [7:0]                    arlen;
    logic [2:0]                    arsize;
    logic [1:0]                    arburst;
    logic                          arvalid;
    logic                          arready;

    logic [TransactionIdWidth-1:0] rid;
    logic [DataWidth-1:0]          rdata;
    logic [1:0]                    rresp;
    logic                          rlast;
    logic                          rvalid;
    logic                          rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/renode_axi_burst_addr_gen.sv
// Per-beat address generator for FIXED/INCR/WRAP bursts, plus detection of bursts the
// splitter refuses to forward.
module renode_axi_burst_addr_gen
    import renode_axi_pkg::*;
#(
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned DataWidth    = 32
) (
    input  logic [AddressWidth-1:0] start_addr_i,
    input  burst_size_t             size_i,
    input  burst_length_t           len_i,
    input  logic [1:0]              burst_i,
    input  burst_length_t           beat_i,
    output logic [AddressWidth-1:0] beat_addr_o,
    output logic                    illegal_o
);
    localparam int unsigned StrobeWidth = DataWidth / 8;
    localparam int unsigned MaxSize     = $clog2(StrobeWidth);

    logic [AddressWidth-1:0] size_mask;
    logic [AddressWidth-1:0] aligned;
    logic [AddressWidth-1:0] incr_addr;
    logic [AddressWidth-1:0] wrap_mask;
    logic                    wrap_len_ok;

    always_comb begin
        size_mask   = (AddressWidth'(1) << size_i) - AddressWidth'(1);
        aligned     = start_addr_i & ~size_mask;
        incr_addr   = aligned + (AddressWidth'(beat_i) << size_i);
        // Wrap boundary is the total burst footprint: (len+1) beats of 2**size bytes.
        wrap_mask   = ((AddressWidth'(len_i) + AddressWidth'(1)) << size_i) - AddressWidth'(1);
        wrap_len_ok = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);

        beat_addr_o = incr_addr;
        case (burst_type_e'(burst_i))
            BurstFixed: beat_addr_o = aligned;
            BurstWrap:  beat_addr_o = (aligned & ~wrap_mask) | (incr_addr & wrap_mask);
            default:    beat_addr_o = incr_addr;
        endcase

        illegal_o = (burst_i == BurstReserved) ||
                    (size_i > burst_size_t'(MaxSize)) ||
                    ((burst_i == BurstWrap) && !wrap_len_ok);
    end

endmodule

// File: rtl/renode_axi_burst_splitter.sv
// Splits every upstream AXI burst into single-beat aligned INCR accesses for the Renode
// subordinate. Read and write paths run independently with one burst each in flight.
module renode_axi_burst_splitter
    import renode_axi_pkg::*;
#(
    parameter int unsigned AddressWidth       = 32,
    parameter int unsigned DataWidth          = 32,
    parameter int unsigned TransactionIdWidth = 8
) (
    input  logic                        aclk,
    input  logic                        areset_n,
    renode_axi_burst_splitter_if.slave  s_axi,
    renode_axi_burst_splitter_if.master m_axi
);

    // Keeps both address readies low while reset is held and for the first cycle after.
    logic en_q;

    w_state_e                      w_state_q, w_state_d;
    logic [TransactionIdWidth-1:0] aw_id_q, aw_id_d;
    logic [AddressWidth-1:0]       aw_addr_q, aw_addr_d;
    burst_length_t                 aw_len_q, aw_len_d;
    burst_size_t                   aw_size_q, aw_size_d;
    logic [1:0]                    aw_burst_q, aw_burst_d;
    burst_length_t                 w_beat_q, w_beat_d;
    response_e                     w_resp_q, w_resp_d;
    logic [AddressWidth-1:0]       aw_beat_addr;
    logic                          aw_illegal;
    logic                          w_last_beat;

    r_state_e                      r_state_q, r_state_d;
    logic [TransactionIdWidth-1:0] ar_id_q, ar_id_d;
    logic [AddressWidth-1:0]       ar_addr_q, ar_addr_d;
    burst_length_t                 ar_len_q, ar_len_d;
    burst_size_t                   ar_size_q, ar_size_d;
    logic [1:0]                    ar_burst_q, ar_burst_d;
    burst_length_t                 r_beat_q, r_beat_d;
    logic [DataWidth-1:0]          r_data_q, r_data_d;
    response_e                     r_resp_q, r_resp_d;
    logic [AddressWidth-1:0]       ar_beat_addr;
    logic                          ar_illegal;
    logic                          r_last_beat;

    logic unused_down_fields;
    assign unused_down_fields = ^{m_axi.bid, m_axi.rid, m_axi.rlast};

    renode_axi_burst_addr_gen #(
        .AddressWidth (AddressWidth),
        .DataWidth    (DataWidth)
    ) u_aw_gen (
        .start_addr_i (aw_addr_q),
        .size_i       (aw_size_q),
        .len_i        (aw_len_q),
        .burst_i      (aw_burst_q),
        .beat_i       (w_beat_q),
        .beat_addr_o  (aw_beat_addr),
        .illegal_o    (aw_illegal)
    );

    renode_axi_burst_addr_gen #(
        .AddressWidth (AddressWidth),
        .DataWidth    (DataWidth)
    ) u_ar_gen (
        .start_addr_i (ar_addr_q),
        .size_i       (ar_size_q),
        .len_i        (ar_len_q),
        .burst_i      (ar_burst_q),
        .beat_i       (r_beat_q),
        .beat_addr_o  (ar_beat_addr),
        .illegal_o    (ar_illegal)
    );

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            en_q       <= 1'b0;
            w_state_q  <= WIdle;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_beat_q   <= '0;
            w_resp_q   <= RespOkay;
        end else begin
            en_q       <= 1'b1;
            w_state_q  <= w_state_d;
            aw_id_q    <= aw_id_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_beat_q   <= w_beat_d;
            w_resp_q   <= w_resp_d;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state_q  <= RIdle;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_beat_q   <= '0;
            r_data_q   <= '0;
            r_resp_q   <= RespOkay;
        end else begin
            r_state_q  <= r_state_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_beat_q   <= r_beat_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
        end
    end

    always_comb begin
        w_state_d   = w_state_q;
        aw_id_d     = aw_id_q;
        aw_addr_d   = aw_addr_q;
        aw_len_d    = aw_len_q;
        aw_size_d   = aw_size_q;
        aw_burst_d  = aw_burst_q;
        w_beat_d    = w_beat_q;
        w_resp_d    = w_resp_q;
        w_last_beat = (w_beat_q == aw_len_q);

        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        s_axi.bid     = aw_id_q;
        s_axi.bresp   = w_resp_q;

        m_axi.awvalid = 1'b0;
        m_axi.awid    = aw_id_q;
        m_axi.awaddr  = aw_beat_addr;
        m_axi.awlen   = '0;
        m_axi.awsize  = aw_size_q;
        m_axi.awburst = BurstIncr;
        m_axi.wvalid  = 1'b0;
        m_axi.wdata   = s_axi.wdata;
        m_axi.wstrb   = s_axi.wstrb;
        m_axi.wlast   = 1'b1;
        m_axi.bready  = 1'b0;

        unique case (w_state_q)
            WIdle: begin
                s_axi.awready = en_q;
                if (en_q && s_axi.awvalid) begin
                    aw_id_d    = s_axi.awid;
                    aw_addr_d  = s_axi.awaddr;
                    aw_len_d   = s_axi.awlen;
                    aw_size_d  = s_axi.awsize;
                    aw_burst_d = s_axi.awburst;
                    w_beat_d   = '0;
                    w_resp_d   = RespOkay;
                    w_state_d  = WAddr;
                end
            end
            WAddr: begin
                if (aw_illegal) begin
                    w_resp_d  = RespSlvErr;
                    w_state_d = WDrain;
                end else begin
                    m_axi.awvalid = 1'b1;
                    if (m_axi.awready) begin
                        w_state_d = WData;
                    end
                end
            end
            WData: begin
                m_axi.wvalid = s_axi.wvalid;
                s_axi.wready = m_axi.wready;
                if (s_axi.wvalid && m_axi.wready) begin
                    if (s_axi.wlast != w_last_beat) begin
                        w_resp_d = max_response(w_resp_q, RespSlvErr);
                    end
                    w_state_d = WResp;
                end
            end
            WResp: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) begin
                    w_resp_d = max_response(w_resp_q, response_e'(m_axi.bresp));
                    if (w_last_beat) begin
                        w_state_d = WBresp;
                    end else begin
                        w_beat_d  = w_beat_q + 8'd1;
                        w_state_d = WAddr;
                    end
                end
            end
            WDrain: begin
                // Refused burst: swallow its data beats so the manager is not stalled.
                s_axi.wready = 1'b1;
                if (s_axi.wvalid) begin
                    if (w_last_beat) begin
                        w_state_d = WBresp;
                    end else begin
                        w_beat_d = w_beat_q + 8'd1;
                    end
                end
            end
            WBresp: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        r_state_d   = r_state_q;
        ar_id_d     = ar_id_q;
        ar_addr_d   = ar_addr_q;
        ar_len_d    = ar_len_q;
        ar_size_d   = ar_size_q;
        ar_burst_d  = ar_burst_q;
        r_beat_d    = r_beat_q;
        r_data_d    = r_data_q;
        r_resp_d    = r_resp_q;
        r_last_beat = (r_beat_q == ar_len_q);

        s_axi.arready = 1'b0;
        s_axi.rvalid  = 1'b0;
        s_axi.rid     = ar_id_q;
        s_axi.rdata   = r_data_q;
        s_axi.rresp   = r_resp_q;
        s_axi.rlast   = r_last_beat;

        m_axi.arvalid = 1'b0;
        m_axi.arid    = ar_id_q;
        m_axi.araddr  = ar_beat_addr;
        m_axi.arlen   = '0;
        m_axi.arsize  = ar_size_q;
        m_axi.arburst = BurstIncr;
        m_axi.rready  = 1'b0;

        unique case (r_state_q)
            RIdle: begin
                s_axi.arready = en_q;
                if (en_q && s_axi.arvalid) begin
                    ar_id_d    = s_axi.arid;
                    ar_addr_d  = s_axi.araddr;
                    ar_len_d   = s_axi.arlen;
                    ar_size_d  = s_axi.arsize;
                    ar_burst_d = s_axi.arburst;
                    r_beat_d   = '0;
                    r_state_d  = RAddr;
                end
            end
            RAddr: begin
                if (ar_illegal) begin
                    r_state_d = RErr;
                end else begin
                    m_axi.arvalid = 1'b1;
                    if (m_axi.arready) begin
                        r_state_d = RData;
                    end
                end
            end
            RData: begin
                m_axi.rready = 1'b1;
                if (m_axi.rvalid) begin
                    r_data_d  = m_axi.rdata;
                    r_resp_d  = response_e'(m_axi.rresp);
                    r_state_d = ROut;
                end
            end
            ROut: begin
                s_axi.rvalid = 1'b1;
                if (s_axi.rready) begin
                    if (r_last_beat) begin
                        r_state_d = RIdle;
                    end else begin
                        r_beat_d  = r_beat_q + 8'd1;
                        r_state_d = RAddr;
                    end
                end
            end
            RErr: begin
                s_axi.rvalid = 1'b1;
                s_axi.rdata  = '0;
                s_axi.rresp  = RespSlvErr;
                if (s_axi.rready) begin
                    if (r_last_beat) begin
                        r_state_d = RIdle;
                    end else begin
                        r_beat_d = r_beat_q + 8'd1;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

endmodule
